id_ex_stage: RTL and testbench

- ID/EX pipeline register and operand-delivery stage of the MIPS pipeline; directly upstream of alu_module.
- Latches decoded instruction fields and controls from ID, decodes alu_sel, and sign/zero-extends the immediate.
- Applies EX/MEM and MEM/WB forwarding and drives alu_module's A, B and alu_sel.
- Detects load-use hazards, inserts bubbles, and carries controls forward to EX/MEM.

---
 rtl/id_ex_stage.sv | 188 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and operand-delivery stage.
// This stage latches the decoded ID fields and decodes the ALU select.
// It extends the immediate, applies EX/MEM and MEM/WB forwarding, and
// inserts a bubble when a load-use hazard is detected.
module id_ex_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall,
   input  logic          flush,
   input  logic          id_valid,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic [15:0]   id_imm,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_rd,
   input  logic [5:0]    id_funct,
   input  logic [1:0]    id_alu_op,
   input  logic          id_alu_src,
   input  logic          id_reg_dst,
   input  logic          id_reg_write,
   input  logic          id_mem_read,
   input  logic          id_mem_write,
   input  logic          id_mem_to_reg,
   input  logic          exm_reg_write,
   input  logic [RW-1:0] exm_rd,
   input  logic [DW-1:0] exm_result,
   input  logic          mwb_reg_write,
   input  logic [RW-1:0] mwb_rd,
   input  logic [DW-1:0] mwb_result,
   output logic [DW-1:0] A,
   output logic [DW-1:0] B,
   output logic [3:0]    alu_sel,
   output logic          ex_valid,
   output logic [RW-1:0] ex_wr_reg,
   output logic [DW-1:0] ex_store_data,
   output logic          ex_reg_write,
   output logic          ex_mem_read,
   output logic          ex_mem_write,
   output logic          ex_mem_to_reg,
   output logic          load_use_stall
);

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_NOR = 4'b1100
   } alu_sel_e;

   // EX-side registers
   logic          r_valid;
   logic [RW-1:0] r_rs;
   logic [RW-1:0] r_rt;
   logic [RW-1:0] r_wr_reg;
   logic [DW-1:0] r_rs_data;
   logic [DW-1:0] r_rt_data;
   logic [DW-1:0] r_ext_imm;
   logic          r_alu_src;
   alu_sel_e      r_alu_sel;
   logic          r_reg_write;
   logic          r_mem_read;
   logic          r_mem_write;
   logic          r_mem_to_reg;

   alu_sel_e      w_alu_sel_dec;
   logic [DW-1:0] w_ext_imm;
   logic          w_load_use;
   logic          w_clear;
   logic          w_load;
   logic [DW-1:0] w_fwd_rs;
   logic [DW-1:0] w_fwd_rt;

   // ALU select decode from the main-control class and the funct field
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_alu_sel_dec = ALU_ADD;
      case (id_alu_op)
         2'b00: w_alu_sel_dec = ALU_ADD;
         2'b01: w_alu_sel_dec = ALU_SUB;
         2'b11: w_alu_sel_dec = ALU_OR;
         default: begin
            case (id_funct)
               6'b100000, 6'b100001: w_alu_sel_dec = ALU_ADD;
               6'b100010, 6'b100011: w_alu_sel_dec = ALU_SUB;
               6'b100100:            w_alu_sel_dec = ALU_AND;
               6'b100101:            w_alu_sel_dec = ALU_OR;
               6'b100111:            w_alu_sel_dec = ALU_NOR;
               6'b101010:            w_alu_sel_dec = ALU_SLT;
               default:              w_alu_sel_dec = ALU_ADD;
            endcase
         end
      endcase
   end

   // ori-class instructions take a zero-extended immediate; all others sign-extend
   assign w_ext_imm = (id_alu_op == 2'b11) ? {{(DW-16){1'b0}}, id_imm}
                                           : {{(DW-16){id_imm[15]}}, id_imm};

   // A load in EX whose destination feeds the ID instruction must be held back one cycle
   assign w_load_use = id_valid & r_valid & r_mem_read & (r_wr_reg != '0) &
                       ((r_wr_reg == id_rs) | (r_wr_reg == id_rt));
   assign load_use_stall = w_load_use;

   // Flush and load-use bubbles override stall; an invalid ID slot captures as a bubble
   assign w_clear = flush | w_load_use | (~stall & ~id_valid);
   assign w_load  = ~stall & id_valid;

   // EX register update: reset, bubble, hold or capture
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every pipeline register is reset, so a bubble state exists before the first capture.
      if (!rst_n) begin
         r_valid      <= 1'b0;
         r_rs         <= '0;
         r_rt         <= '0;
         r_wr_reg     <= '0;
         r_rs_data    <= '0;
         r_rt_data    <= '0;
         r_ext_imm    <= '0;
         r_alu_src    <= 1'b0;
         r_alu_sel    <= ALU_ADD;
         r_reg_write  <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_to_reg <= 1'b0;
      end else if (w_clear) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         r_valid      <= 1'b0;
         r_rs         <= '0;
         r_rt         <= '0;
         r_wr_reg     <= '0;
         r_rs_data    <= '0;
         r_rt_data    <= '0;
         r_ext_imm    <= '0;
         r_alu_src    <= 1'b0;
         r_alu_sel    <= ALU_ADD;
         r_reg_write  <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_to_reg <= 1'b0;
      end else if (w_load) begin
         r_valid      <= 1'b1;
         r_rs         <= id_rs;
         r_rt         <= id_rt;
         r_wr_reg     <= id_reg_dst ? id_rd : id_rt;
         r_rs_data    <= id_rs_data;
         r_rt_data    <= id_rt_data;
         r_ext_imm    <= w_ext_imm;
         r_alu_src    <= id_alu_src;
         r_alu_sel    <= w_alu_sel_dec;
         r_reg_write  <= id_reg_write;
         r_mem_read   <= id_mem_read;
         r_mem_write  <= id_mem_write;
         r_mem_to_reg <= id_mem_to_reg;
      end
   end

   // Forwarding: EX/MEM beats MEM/WB, and register 0 is never forwarded
   always_comb begin
      w_fwd_rs = r_rs_data;
      w_fwd_rt = r_rt_data;
      if (exm_reg_write && (exm_rd != '0) && (exm_rd == r_rs))
         w_fwd_rs = exm_result;
      else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == r_rs))
         w_fwd_rs = mwb_result;
      if (exm_reg_write && (exm_rd != '0) && (exm_rd == r_rt))
         w_fwd_rt = exm_result;
      else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == r_rt))
         w_fwd_rt = mwb_result;
   end

   assign A             = w_fwd_rs;
   assign B             = r_alu_src ? r_ext_imm : w_fwd_rt;
   assign ex_store_data = w_fwd_rt;
   assign alu_sel       = r_alu_sel;
   assign ex_valid      = r_valid;
   assign ex_wr_reg     = r_wr_reg;
   assign ex_reg_write  = r_reg_write;
   assign ex_mem_read   = r_mem_read;
   assign ex_mem_write  = r_mem_write;
   assign ex_mem_to_reg = r_mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage.
// Directed steps come first, followed by randomized cycles.
// Every cycle is checked against a behavioural model of the EX slot.
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          stall, flush, id_valid;
   logic [DW-1:0] id_rs_data, id_rt_data;
   logic [15:0]   id_imm;
   logic [RW-1:0] id_rs, id_rt, id_rd;
   logic [5:0]    id_funct;
   logic [1:0]    id_alu_op;
   logic          id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
   logic          exm_reg_write, mwb_reg_write;
   logic [RW-1:0] exm_rd, mwb_rd;
   logic [DW-1:0] exm_result, mwb_result;
   logic [DW-1:0] A, B, ex_store_data;
   logic [3:0]    alu_sel;
   logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_stall;
   logic [RW-1:0] ex_wr_reg;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.DW(DW), .RW(RW)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
      .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_mem_to_reg(id_mem_to_reg), .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
      .exm_result(exm_result), .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd),
      .mwb_result(mwb_result), .A(A), .B(B), .alu_sel(alu_sel), .ex_valid(ex_valid),
      .ex_wr_reg(ex_wr_reg), .ex_store_data(ex_store_data), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
      .load_use_stall(load_use_stall)
   );

   // Reference model of the instruction sitting in EX
   typedef struct {
      bit        valid;
      int        rs, rt, wr;
      bit [31:0] rs_data, rt_data, imm;
      bit        alu_src, reg_write, mem_read, mem_write, mem_to_reg;
      int        sel;
   } ex_slot_t;

   ex_slot_t m;

   function automatic ex_slot_t empty_slot();
      ex_slot_t s;
      s = '{valid: 0, rs: 0, rt: 0, wr: 0, rs_data: 0, rt_data: 0, imm: 0,
            alu_src: 0, reg_write: 0, mem_read: 0, mem_write: 0, mem_to_reg: 0, sel: 2};
      return s;
   endfunction

   function automatic int sel_of(int op, int funct);
      if (op == 0) return 2;
      if (op == 1) return 6;
      if (op == 3) return 1;
      case (funct)
         32, 33:  return 2;
         34, 35:  return 6;
         36:      return 0;
         37:      return 1;
         39:      return 12;
         42:      return 7;
         default: return 2;
      endcase
   endfunction

   function automatic bit [31:0] forward(int src, bit [31:0] regval);
      if (exm_reg_write && src != 0 && int'(exm_rd) == src) return exm_result;
      if (mwb_reg_write && src != 0 && int'(mwb_rd) == src) return mwb_result;
      return regval;
   endfunction

   function automatic bit model_hazard();
      return id_valid && m.valid && m.mem_read && m.wr != 0 &&
             (m.wr == int'(id_rs) || m.wr == int'(id_rt));
   endfunction

   task automatic model_edge();
      if (!rst_n) m = empty_slot();
      else if (flush || model_hazard()) m = empty_slot();
      else if (stall) ;
      else if (!id_valid) m = empty_slot();
      else begin
         m.valid      = 1;
         m.rs         = int'(id_rs);
         m.rt         = int'(id_rt);
         m.wr         = id_reg_dst ? int'(id_rd) : int'(id_rt);
         m.rs_data    = id_rs_data;
         m.rt_data    = id_rt_data;
         m.imm        = (id_alu_op == 3) ? 32'(id_imm) : 32'(signed'(id_imm));
         m.alu_src    = id_alu_src;
         m.reg_write  = id_reg_write;
         m.mem_read   = id_mem_read;
         m.mem_write  = id_mem_write;
         m.mem_to_reg = id_mem_to_reg;
         m.sel        = sel_of(int'(id_alu_op), int'(id_funct));
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string p);
      bit [31:0] frt;
      frt = forward(m.rt, m.rt_data);
      check({p, "_A"},       A,                     forward(m.rs, m.rs_data));
      check({p, "_B"},       B,                     m.alu_src ? m.imm : frt);
      check({p, "_store"},   ex_store_data,         frt);
      check({p, "_sel"},     32'(alu_sel),          32'(m.sel));
      check({p, "_valid"},   32'(ex_valid),         32'(m.valid));
      check({p, "_wr"},      32'(ex_wr_reg),        32'(m.wr));
      check({p, "_ctl"},     {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
                             {28'd0, m.reg_write, m.mem_read, m.mem_write, m.mem_to_reg});
      check({p, "_lus"},     32'(load_use_stall),   32'(model_hazard()));
   endtask

   task automatic tick(input string p);
      @(posedge clk);
      model_edge();
      #1;
      check_all(p);
   endtask

   task automatic clr_id();
      stall = 0; flush = 0; id_valid = 0;
      id_rs_data = 0; id_rt_data = 0; id_imm = 0;
      id_rs = 0; id_rt = 0; id_rd = 0; id_funct = 0; id_alu_op = 0;
      id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0;
      id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
      exm_reg_write = 0; exm_rd = 0; exm_result = 0;
      mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
   endtask

   task automatic drive_add();
      clr_id();
      id_valid = 1; id_rs = 1; id_rt = 2; id_rd = 3;
      id_rs_data = 5; id_rt_data = 7; id_alu_op = 2'b10; id_funct = 6'b100000;
      id_reg_dst = 1; id_reg_write = 1;
   endtask

   initial begin
      m = empty_slot();
      rst_n = 0;
      clr_id();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      check("reset_sel", 32'(alu_sel), 32'h2);
      rst_n = 1;

      // add $3,$1,$2
      drive_add();
      tick("add");
      check("add_A", A, 32'd5);
      check("add_B", B, 32'd7);
      check("add_sel", 32'(alu_sel), 32'h2);
      check("add_wr", 32'(ex_wr_reg), 32'd3);
      check("add_valid", 32'(ex_valid), 32'd1);

      // addi with negative immediate
      clr_id();
      id_valid = 1; id_rs = 1; id_rt = 4; id_imm = 16'hFFFC; id_alu_src = 1; id_reg_write = 1;
      tick("addi");
      check("addi_B", B, 32'hFFFF_FFFC);
      check("addi_wr", 32'(ex_wr_reg), 32'd4);

      // ori zero-extends
      id_imm = 16'h8001; id_alu_op = 2'b11;
      tick("ori");
      check("ori_B", B, 32'h0000_8001);
      check("ori_sel", 32'(alu_sel), 32'h1);

      // forwarding on rs=4
      clr_id();
      id_valid = 1; id_rs = 4; id_rs_data = 1; id_rt = 6; id_rt_data = 9;
      tick("fw_cap");
      exm_reg_write = 1; exm_rd = 4; exm_result = 32'hAA;
      mwb_reg_write = 1; mwb_rd = 4; mwb_result = 32'hBB;
      #1; check_all("fw_exm"); check("fw_exm_A", A, 32'hAA);
      exm_reg_write = 0;
      #1; check_all("fw_mwb"); check("fw_mwb_A", A, 32'hBB);
      mwb_rd = 6;
      #1; check("fw_rt_store", ex_store_data, 32'hBB);
      clr_id();
      id_valid = 1; id_rs = 0; id_rs_data = 1;
      tick("fw0_cap");
      exm_reg_write = 1; exm_rd = 0; exm_result = 32'hAA;
      mwb_reg_write = 1; mwb_rd = 0; mwb_result = 32'hBB;
      #1; check("fw_r0_A", A, 32'd1);

      // load-use hazard
      clr_id();
      id_valid = 1; id_rs = 2; id_rt = 5; id_alu_src = 1; id_mem_read = 1;
      id_reg_write = 1; id_mem_to_reg = 1;
      tick("lw");
      clr_id();
      id_valid = 1; id_rs = 5; id_rt = 7;
      #1; check("lu_stall", 32'(load_use_stall), 32'd1);
      stall = 1;
      tick("lu_bubble");
      check("lu_valid", 32'(ex_valid), 32'd0);
      check("lu_mread", 32'(ex_mem_read), 32'd0);
      clr_id();
      id_valid = 1; id_rs = 2; id_rt = 0; id_alu_src = 1; id_mem_read = 1; id_reg_write = 1;
      tick("lw0");
      clr_id();
      id_valid = 1; id_rs = 0; id_rt = 0;
      #1; check("lu_r0", 32'(load_use_stall), 32'd0);

      // stall holds for 3 cycles while ID changes
      drive_add();
      tick("st_cap");
      for (int i = 0; i < 3; i++) begin
         stall = 1; id_rd = RW'(10 + i); id_rs_data = 32'(100 + i); id_funct = 6'b100010;
         tick("stall");
         check("stall_wr", 32'(ex_wr_reg), 32'd3);
         check("stall_A", A, 32'd5);
      end
      stall = 1; flush = 1;
      tick("stfl");
      check("stfl_valid", 32'(ex_valid), 32'd0);

      // asynchronous reset between edges
      clr_id();
      id_valid = 1; id_alu_op = 2'b01; id_reg_write = 1; id_rs = 3; id_rs_data = 42;
      tick("pre_rst");
      #2 rst_n = 0;
      m = empty_slot();
      #1;
      check("rst_valid", 32'(ex_valid), 32'd0);
      check("rst_rw", 32'(ex_reg_write), 32'd0);
      check("rst_sel", 32'(alu_sel), 32'h2);
      check_all("rst_mid");
      tick("rst_hold");
      rst_n = 1;
      drive_add();
      tick("post_rst");
      check("post_rst_A", A, 32'd5);

      // randomized cycles
      for (int n = 0; n < 300; n++) begin
         id_valid      = ($urandom_range(0, 3) != 0);
         stall         = ($urandom_range(0, 3) == 0);
         flush         = ($urandom_range(0, 7) == 0);
         id_rs         = RW'($urandom_range(0, 7));
         id_rt         = RW'($urandom_range(0, 7));
         id_rd         = RW'($urandom_range(0, 7));
         id_rs_data    = $urandom;
         id_rt_data    = $urandom;
         id_imm        = 16'($urandom);
         id_funct      = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(32, 42)) : 6'($urandom);
         id_alu_op     = 2'($urandom);
         id_alu_src    = 1'($urandom);
         id_reg_dst    = 1'($urandom);
         id_reg_write  = 1'($urandom);
         id_mem_read   = ($urandom_range(0, 2) == 0);
         id_mem_write  = 1'($urandom);
         id_mem_to_reg = 1'($urandom);
         exm_reg_write = 1'($urandom);
         exm_rd        = RW'($urandom_range(0, 7));
         exm_result    = $urandom;
         mwb_reg_write = 1'($urandom);
         mwb_rd        = RW'($urandom_range(0, 7));
         mwb_result    = $urandom;
         #1; check_all("rnd_pre");
         tick("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
